// File: rtl/binary_bbox_detect.sv
// Bounding box and foreground pixel count of a binary raster frame.
// A result is published with a one-cycle bbox_valid pulse after the last pixel of each frame.
module binary_bbox_detect #(
    parameter  int DATA_WIDTH = 8,
    parameter  int IMG_WIDTH  = 10,
    parameter  int IMG_HEIGHT = 4,
    parameter  int MIN_PIXELS = 1,
    localparam int XW         = $clog2(IMG_WIDTH),
    localparam int YW         = $clog2(IMG_HEIGHT),
    localparam int CW         = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    output logic [XW-1:0]         bbox_x_min,
    output logic [XW-1:0]         bbox_x_max,
    output logic [YW-1:0]         bbox_y_min,
    output logic [YW-1:0]         bbox_y_max,
    output logic [CW-1:0]         bbox_count,
    output logic                  bbox_found,
    output logic                  bbox_valid
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] C_MIN  = CW'(MIN_PIXELS);

    logic [XW-1:0] r_x_cnt;
    logic [YW-1:0] r_y_cnt;

    logic [XW-1:0] r_wx_min, r_wx_max;
    logic [YW-1:0] r_wy_min, r_wy_max;
    logic [CW-1:0] r_wcount;

    logic [XW-1:0] r_x_min, r_x_max;
    logic [YW-1:0] r_y_min, r_y_max;
    logic [CW-1:0] r_count;
    logic          r_found;
    logic          r_valid;

    logic          w_is_fg;
    logic          w_x_last;
    logic          w_y_last;
    logic [XW-1:0] w_nx_min, w_nx_max;
    logic [YW-1:0] w_ny_min, w_ny_max;
    logic [CW-1:0] w_ncount;
    logic          w_found;

    assign w_is_fg  = |pixel_in;
    assign w_x_last = (r_x_cnt == X_LAST);
    assign w_y_last = (r_y_cnt == Y_LAST);

    // Working set including the current pixel's contribution
    assign w_nx_min = (w_is_fg && (r_x_cnt < r_wx_min)) ? r_x_cnt : r_wx_min;
    assign w_nx_max = (w_is_fg && (r_x_cnt > r_wx_max)) ? r_x_cnt : r_wx_max;
    assign w_ny_min = (w_is_fg && (r_y_cnt < r_wy_min)) ? r_y_cnt : r_wy_min;
    assign w_ny_max = (w_is_fg && (r_y_cnt > r_wy_max)) ? r_y_cnt : r_wy_max;
    assign w_ncount = r_wcount + {{(CW-1){1'b0}}, w_is_fg};
    assign w_found  = (w_ncount >= C_MIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt  <= '0;
            r_y_cnt  <= '0;
            r_wx_min <= X_LAST;
            r_wx_max <= '0;
            r_wy_min <= Y_LAST;
            r_wy_max <= '0;
            r_wcount <= '0;
            r_x_min  <= '0;
            r_x_max  <= '0;
            r_y_min  <= '0;
            r_y_max  <= '0;
            r_count  <= '0;
            r_found  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (pixel_in_valid) begin
                if (w_x_last) begin
                    r_x_cnt <= '0;
                    r_y_cnt <= w_y_last ? '0 : r_y_cnt + YW'(1);
                end else begin
                    r_x_cnt <= r_x_cnt + XW'(1);
                end

                if (w_x_last && w_y_last) begin
                    // Coordinates are meaningless without a detection, so report zeros
                    r_x_min  <= w_found ? w_nx_min : '0;
                    r_x_max  <= w_found ? w_nx_max : '0;
                    r_y_min  <= w_found ? w_ny_min : '0;
                    r_y_max  <= w_found ? w_ny_max : '0;
                    r_count  <= w_ncount;
                    r_found  <= w_found;
                    r_valid  <= 1'b1;
                    r_wx_min <= X_LAST;
                    r_wx_max <= '0;
                    r_wy_min <= Y_LAST;
                    r_wy_max <= '0;
                    r_wcount <= '0;
                end else begin
                    r_wx_min <= w_nx_min;
                    r_wx_max <= w_nx_max;
                    r_wy_min <= w_ny_min;
                    r_wy_max <= w_ny_max;
                    r_wcount <= w_ncount;
                end
            end
        end
    end

    assign bbox_x_min = r_x_min;
    assign bbox_x_max = r_x_max;
    assign bbox_y_min = r_y_min;
    assign bbox_y_max = r_y_max;
    assign bbox_count = r_count;
    assign bbox_found = r_found;
    assign bbox_valid = r_valid;

endmodule

// File: tb/tb_binary_bbox_detect.sv
// Bench for binary_bbox_detect: two instances (MIN_PIXELS 1 and 3) share one stream,
// each cycle is checked against a frame-array reference model.
module tb_binary_bbox_detect;

    localparam int W = 10;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pixel_in;
    logic       pixel_in_valid;

    logic [3:0] xmin_a, xmax_a, xmin_b, xmax_b;
    logic [1:0] ymin_a, ymax_a, ymin_b, ymax_b;
    logic [5:0] cnt_a, cnt_b;
    logic       found_a, found_b, valid_a, valid_b;

    always #5 clk = ~clk;

    binary_bbox_detect #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(1)) dut_a (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
        .bbox_x_min(xmin_a), .bbox_x_max(xmax_a), .bbox_y_min(ymin_a), .bbox_y_max(ymax_a),
        .bbox_count(cnt_a), .bbox_found(found_a), .bbox_valid(valid_a)
    );

    binary_bbox_detect #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(3)) dut_b (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
        .bbox_x_min(xmin_b), .bbox_x_max(xmax_b), .bbox_y_min(ymin_b), .bbox_y_max(ymax_b),
        .bbox_count(cnt_b), .bbox_found(found_b), .bbox_valid(valid_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: pixels received so far in the current frame
    bit frame_fg[N];
    int idx;
    bit e_pulse;
    int e_xmin[2], e_xmax[2], e_ymin[2], e_ymax[2], e_cnt[2], e_found[2];
    int pulses_seen;

    bit pat[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear_outputs();
        for (int k = 0; k < 2; k++) begin
            e_xmin[k] = 0; e_xmax[k] = 0; e_ymin[k] = 0; e_ymax[k] = 0;
            e_cnt[k] = 0; e_found[k] = 0;
        end
    endtask

    task automatic model_finish_frame();
        int cnt, xmn, xmx, ymn, ymx, mp;
        cnt = 0; xmn = W; xmx = -1; ymn = H; ymx = -1;
        for (int i = 0; i < N; i++) begin
            if (frame_fg[i]) begin
                cnt++;
                if (i % W < xmn) xmn = i % W;
                if (i % W > xmx) xmx = i % W;
                if (i / W < ymn) ymn = i / W;
                if (i / W > ymx) ymx = i / W;
            end
        end
        for (int k = 0; k < 2; k++) begin
            mp = (k == 0) ? 1 : 3;
            e_cnt[k]   = cnt;
            e_found[k] = (cnt >= mp) ? 1 : 0;
            e_xmin[k]  = e_found[k] ? xmn : 0;
            e_xmax[k]  = e_found[k] ? xmx : 0;
            e_ymin[k]  = e_found[k] ? ymn : 0;
            e_ymax[k]  = e_found[k] ? ymx : 0;
        end
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare everything
    task automatic cyc(input bit v, input logic [7:0] p, input bit r);
        rst = r;
        pixel_in_valid = v;
        pixel_in = p;
        @(posedge clk);
        #1;
        e_pulse = 1'b0;
        if (r) begin
            idx = 0;
            for (int i = 0; i < N; i++) frame_fg[i] = 1'b0;
            model_clear_outputs();
        end else if (v) begin
            frame_fg[idx] = (p != 8'd0);
            idx++;
            if (idx == N) begin
                model_finish_frame();
                for (int i = 0; i < N; i++) frame_fg[i] = 1'b0;
                idx = 0;
                e_pulse = 1'b1;
            end
        end
        if (valid_a === 1'b1) pulses_seen++;
        chk("valid_a", valid_a, e_pulse);
        chk("valid_b", valid_b, e_pulse);
        chk("xmin_a", xmin_a, e_xmin[0]);
        chk("xmax_a", xmax_a, e_xmax[0]);
        chk("ymin_a", ymin_a, e_ymin[0]);
        chk("ymax_a", ymax_a, e_ymax[0]);
        chk("count_a", cnt_a, e_cnt[0]);
        chk("found_a", found_a, e_found[0]);
        chk("xmin_b", xmin_b, e_xmin[1]);
        chk("xmax_b", xmax_b, e_xmax[1]);
        chk("ymin_b", ymin_b, e_ymin[1]);
        chk("ymax_b", ymax_b, e_ymax[1]);
        chk("count_b", cnt_b, e_cnt[1]);
        chk("found_b", found_b, e_found[1]);
    endtask

    // Send the first n pixels of pat, with invalid gap cycles inserted at gap_pct percent
    task automatic send_pat(input int gap_pct, input int n);
        logic [7:0] val;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) cyc(1'b0, 8'($urandom_range(0, 255)), 1'b0);
            val = pat[i] ? 8'($urandom_range(1, 255)) : 8'd0;
            cyc(1'b1, val, 1'b0);
        end
    endtask

    task automatic pat_clear();
        for (int i = 0; i < N; i++) pat[i] = 1'b0;
    endtask

    task automatic pat_set(input int x, input int y);
        pat[y * W + x] = 1'b1;
    endtask

    initial begin
        int p0;
        idx = 0;
        pulses_seen = 0;
        e_pulse = 1'b0;
        for (int i = 0; i < N; i++) frame_fg[i] = 1'b0;
        model_clear_outputs();

        cyc(1'b0, 8'd0, 1'b1);
        cyc(1'b1, 8'hFF, 1'b1);

        // All-zero frame
        pat_clear();
        send_pat(0, N);
        cyc(1'b0, 8'd0, 1'b0);

        // Three sparse foreground pixels, with gaps
        pat_clear();
        pat_set(2, 1); pat_set(7, 2); pat_set(4, 3);
        send_pat(30, N);
        cyc(1'b0, 8'd0, 1'b0);

        // Full frame then empty frame, back to back
        for (int i = 0; i < N; i++) pat[i] = 1'b1;
        send_pat(0, N);
        pat_clear();
        send_pat(0, N);

        // Single pixel at the very last position, valid toggled
        pat_clear();
        pat_set(9, 3);
        send_pat(50, N);
        cyc(1'b0, 8'd0, 1'b0);

        // Reset mid-frame discards the partial frame
        p0 = pulses_seen;
        for (int i = 0; i < N; i++) pat[i] = ($urandom_range(0, 1) == 1);
        send_pat(20, 25);
        cyc(1'b0, 8'd0, 1'b1);
        chk("no_pulse_partial", pulses_seen, p0);
        pat_clear();
        pat_set(0, 0);
        send_pat(10, N);
        cyc(1'b0, 8'd0, 1'b0);

        // Two foreground pixels: below the MIN_PIXELS=3 threshold of dut_b
        pat_clear();
        pat_set(3, 0); pat_set(6, 2);
        send_pat(0, N);

        // Foreground first pixel directly after a completed frame
        pat_clear();
        pat_set(0, 0); pat_set(5, 1); pat_set(8, 3);
        send_pat(0, N);
        cyc(1'b0, 8'd0, 1'b0);

        // Random frames of varying density and gap rate
        for (int f = 0; f < 8; f++) begin
            int dens;
            dens = $urandom_range(0, 30);
            for (int i = 0; i < N; i++) pat[i] = ($urandom_range(0, 99) < dens);
            send_pat($urandom_range(0, 40), N);
        end

        // Reset coinciding with the last pixel wins: no pulse, outputs cleared
        for (int i = 0; i < N; i++) pat[i] = ($urandom_range(0, 1) == 1);
        send_pat(0, N - 1);
        p0 = pulses_seen;
        cyc(1'b1, 8'hFF, 1'b1);
        cyc(1'b0, 8'd0, 1'b0);
        chk("no_pulse_rst_last", pulses_seen, p0);

        // Frame after that reset starts at (0,0)
        pat_clear();
        pat_set(1, 0); pat_set(9, 1); pat_set(2, 2); pat_set(0, 3);
        send_pat(25, N);
        cyc(1'b0, 8'd0, 1'b0);
        cyc(1'b0, 8'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
